xfer_word_mover: RTL and testbench
==================================

# xfer_word_mover

Sequencer that moves one 16-bit word from a source transfer register to a destination transfer register. It sits directly upstream of the bank of transfer registers and generates their active-low bus strobes. A move uses either the 16-bit xfer bus in one strobe cycle, or the 8-bit main bus as a low-byte phase followed by a high-byte phase. Instruction control issues moves through a valid/ready handshake and receives a one-cycle completion pulse.

## Interface

Parameters:
- NUM_REGS, 4: number of transfer registers controlled.
- WIDTH_SEL, 2: register select width; NUM_REGS <= 2**WIDTH_SEL.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  move request present.
- req_ready  out  1  high while idle; a request is accepted on a posedge where req_valid & req_ready.
- req_src  in  WIDTH_SEL  source register index.
- req_dst  in  WIDTH_SEL  destination register index.
- req_mode  in  1  0 = xfer bus (one cycle); 1 = main bus (two cycles, low then high).
- busy  out  1  high from the acceptance edge until the final strobe cycle ends.
- done  out  1  one-cycle pulse after destination is updated.
- assert_xfer_n  out  NUM_REGS  per-register xfer-bus drive strobe, active low.
- load_xfer_n  out  NUM_REGS  per-register xfer-bus load strobe, active low.
- assertlow_main_n, asserthigh_main_n  out  NUM_REGS each  per-register main-bus low/high byte drive, active low.
- loadlow_main_n, loadhigh_main_n  out  NUM_REGS each  per-register main-bus low/high byte load, active low.

## Operation

- States: IDLE, XFER, LOW, HIGH.
- IDLE: req_ready=1, busy=0, all strobes high.
  - On accept, latch src/dst/mode.
  - Next state is XFER when mode=0, otherwise LOW.
- XFER: assert_xfer_n[src]=0, load_xfer_n[dst]=0; next state IDLE.
- LOW: assertlow_main_n[src]=0, loadlow_main_n[dst]=0; next state HIGH.
- HIGH: asserthigh_main_n[src]=0, loadhigh_main_n[dst]=0; next state IDLE.
- done=1 for exactly the first IDLE cycle after XFER or HIGH.
- Strobe rules:
  - At most one source drive strobe and one destination load strobe are low in any cycle.
  - Strobes are one-hot-low, registered, and glitch-free.
- src==dst: the move is accepted, then no strobes are asserted. The FSM still passes through XFER, or LOW then HIGH, so latency is unchanged and done still pulses.
- src or dst >= NUM_REGS: the move is accepted; strobes for the out-of-range index stay high. done still pulses.
- Request inputs are ignored while busy; req_ready=0 in all non-IDLE states.
- Reset (any state, including mid-move):
  - Next edge forces IDLE, all strobes high, busy=0, done=0, latched fields 0.
  - A half-completed main-bus move leaves the destination with only its low byte updated. This is the required behaviour.

## Timing

- Acceptance edge E0. Xfer move: strobes low in cycle E0..E1; destination loads at E1; done high in cycle E1..E2.
- Main move: low-byte strobes in E0..E1, high-byte strobes in E1..E2, done in E2..E3.
- Back-to-back: req_ready=1 during the done cycle, so a new request can be accepted at the same edge that ends done.
  - Throughput: one xfer move per 2 cycles, one main move per 3 cycles.
- done and a new acceptance may coincide; done never lasts more than one cycle.
- All outputs are registered; there is no combinational path from inputs to strobes.

## Configuration

- XFER_MOVER_BYTE_EN defined: main-bus path present (LOW/HIGH states, main strobes driven as above).
- XFER_MOVER_BYTE_EN undefined:
  - req_mode is ignored and every move uses XFER.
  - LOW/HIGH states are not compiled in.
  - All four main-bus strobe outputs are tied high.

## Structure

- Package xfer_mover_pkg holds:
  - the state enum (IDLE, XFER, LOW, HIGH);
  - mode constants MODE_XFER=0, MODE_MAIN=1;
  - the strobe-inactive constant (all ones).
- One sub-module, sel_strobe_n: turns an index plus an enable into a NUM_REGS-wide active-low one-hot vector. When disabled or the index is out of range, the output is all ones. It is instantiated once per strobe group.

## Test plan

- Reset, then idle 3 cycles: req_ready=1, busy=0, done=0, all strobes 0xF (NUM_REGS=4).
- Xfer move src=1, dst=2: assert_xfer_n=4'b1101 and load_xfer_n=4'b1011 for exactly 1 cycle, then done=1 for 1 cycle. Total 2 cycles accept-to-ready.
- Main move src=3, dst=0: cycle 1 assertlow_main_n=4'b0111 and loadlow_main_n=4'b1110; cycle 2 asserthigh_main_n=4'b0111 and loadhigh_main_n=4'b1110; done in cycle 3.
- Back-to-back: req_valid held high with two queued xfer moves. Second is accepted in the first move's done cycle; the two strobe cycles are separated by exactly 1 cycle.
- Reset asserted during the LOW cycle of a main move: next cycle all strobes 0xF, no HIGH phase, done never pulses, req_ready=1.
- src==dst=2 main move: no strobe goes low for 2 cycles, done pulses in cycle 3. With XFER_MOVER_BYTE_EN undefined, the same request completes as a 1-cycle move with no strobes.

Source files
------------

// File: rtl/xfer_mover_pkg.sv
// Shared types and constants for the transfer-register word mover.
// State encoding, move-mode codes and the inactive (all-ones) strobe level.
package xfer_mover_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        LOW  = 2'd2,
        HIGH = 2'd3
    } state_t;

    localparam logic MODE_XFER = 1'b0;
    localparam logic MODE_MAIN = 1'b1;

    // Sliced down to NUM_REGS by each user.
    localparam logic [63:0] STRB_INACTIVE_N = '1;

endpackage

// File: rtl/xfer_word_mover_sel_strobe_n.sv
// Index + enable to active-low one-hot strobe vector; purely combinational, zero latency.
// No backpressure; disabled or out-of-range index yields all ones.
module sel_strobe_n #(
    parameter int NUM_REGS  = 4,
    parameter int WIDTH_SEL = 2
) (
    input  logic                 en,
    input  logic [WIDTH_SEL-1:0] idx,
    output logic [NUM_REGS-1:0]  strb_n
);

    // An index with no matching register simply finds no bit to clear.
    always_comb begin
        strb_n = '1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && (idx == i[WIDTH_SEL-1:0])) begin
                strb_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/xfer_word_mover.sv
// Moves one 16-bit word between transfer registers: 1 strobe cycle on the xfer bus, or low+high on the main bus.
// Latency: done pulses 2 (xfer) or 3 (main) cycles after acceptance; req_ready low while a move is in flight.
// Main-bus path only exists with XFER_MOVER_BYTE_EN defined; otherwise every move uses the xfer bus.
module xfer_word_mover #(
    parameter int NUM_REGS  = 4,
    parameter int WIDTH_SEL = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH_SEL-1:0] req_src,
    input  logic [WIDTH_SEL-1:0] req_dst,
    input  logic                 req_mode,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_REGS-1:0]  assert_xfer_n,
    output logic [NUM_REGS-1:0]  load_xfer_n,
    output logic [NUM_REGS-1:0]  assertlow_main_n,
    output logic [NUM_REGS-1:0]  asserthigh_main_n,
    output logic [NUM_REGS-1:0]  loadlow_main_n,
    output logic [NUM_REGS-1:0]  loadhigh_main_n
);

    import xfer_mover_pkg::*;

    localparam logic [NUM_REGS-1:0] STRB_OFF = STRB_INACTIVE_N[NUM_REGS-1:0];

    state_t               state_q, state_d;
    logic [WIDTH_SEL-1:0] src_q, src_d;
    logic [WIDTH_SEL-1:0] dst_q, dst_d;
    logic                 busy_q, done_q;
    logic                 accept;
    logic                 move_en;

    logic [NUM_REGS-1:0]  ax_d, lx_d;
    logic [NUM_REGS-1:0]  ax_q, lx_q;

`ifdef XFER_MOVER_BYTE_EN
    logic                 mode_q, mode_d;
`else
    logic                 unused_req_mode;
    assign unused_req_mode = req_mode;
`endif

    assign accept    = req_valid && (state_q == IDLE);
    assign move_en   = (src_d != dst_d);
    assign req_ready = ~busy_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
`ifdef XFER_MOVER_BYTE_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    src_d = req_src;
                    dst_d = req_dst;
`ifdef XFER_MOVER_BYTE_EN
                    mode_d  = req_mode;
                    state_d = (req_mode == MODE_MAIN) ? LOW : XFER;
`else
                    state_d = XFER;
`endif
                end
            end
            XFER:    state_d = IDLE;
`ifdef XFER_MOVER_BYTE_EN
            LOW:     state_d = HIGH;
            HIGH:    state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from next-state values and registered, so each
    // strobe is a clean flop output that is low for exactly its state cycle.
    sel_strobe_n #(.NUM_REGS(NUM_REGS), .WIDTH_SEL(WIDTH_SEL)) u_sel_ax (
        .en     ((state_d == XFER) && move_en),
        .idx    (src_d),
        .strb_n (ax_d)
    );

    sel_strobe_n #(.NUM_REGS(NUM_REGS), .WIDTH_SEL(WIDTH_SEL)) u_sel_lx (
        .en     ((state_d == XFER) && move_en),
        .idx    (dst_d),
        .strb_n (lx_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ax_q    <= STRB_OFF;
            lx_q    <= STRB_OFF;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_q == XFER) || (state_q == HIGH);
            ax_q    <= ax_d;
            lx_q    <= lx_d;
        end
    end

    assign assert_xfer_n = ax_q;
    assign load_xfer_n   = lx_q;

`ifdef XFER_MOVER_BYTE_EN
    logic [NUM_REGS-1:0] al_d, ll_d, ah_d, lh_d;
    logic [NUM_REGS-1:0] al_q, ll_q, ah_q, lh_q;
    logic                main_low_en, main_high_en;

    assign main_low_en  = (state_d == LOW)  && (mode_d == MODE_MAIN) && move_en;
    assign main_high_en = (state_d == HIGH) && (mode_d == MODE_MAIN) && move_en;

    sel_strobe_n #(.NUM_REGS(NUM_REGS), .WIDTH_SEL(WIDTH_SEL)) u_sel_al (
        .en     (main_low_en),
        .idx    (src_d),
        .strb_n (al_d)
    );

    sel_strobe_n #(.NUM_REGS(NUM_REGS), .WIDTH_SEL(WIDTH_SEL)) u_sel_ll (
        .en     (main_low_en),
        .idx    (dst_d),
        .strb_n (ll_d)
    );

    sel_strobe_n #(.NUM_REGS(NUM_REGS), .WIDTH_SEL(WIDTH_SEL)) u_sel_ah (
        .en     (main_high_en),
        .idx    (src_d),
        .strb_n (ah_d)
    );

    sel_strobe_n #(.NUM_REGS(NUM_REGS), .WIDTH_SEL(WIDTH_SEL)) u_sel_lh (
        .en     (main_high_en),
        .idx    (dst_d),
        .strb_n (lh_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_XFER;
            al_q   <= STRB_OFF;
            ll_q   <= STRB_OFF;
            ah_q   <= STRB_OFF;
            lh_q   <= STRB_OFF;
        end else begin
            mode_q <= mode_d;
            al_q   <= al_d;
            ll_q   <= ll_d;
            ah_q   <= ah_d;
            lh_q   <= lh_d;
        end
    end

    assign assertlow_main_n  = al_q;
    assign loadlow_main_n    = ll_q;
    assign asserthigh_main_n = ah_q;
    assign loadhigh_main_n   = lh_q;
`else
    assign assertlow_main_n  = STRB_OFF;
    assign loadlow_main_n    = STRB_OFF;
    assign asserthigh_main_n = STRB_OFF;
    assign loadhigh_main_n   = STRB_OFF;
`endif

endmodule

// File: tb/tb_xfer_word_mover.sv
// Scoreboard bench for xfer_word_mover: per-cycle expected output records queued at request time.
module tb_xfer_word_mover;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_src;
    logic [1:0] req_dst;
    logic       req_mode;
    logic       busy;
    logic       done;
    logic [3:0] assert_xfer_n, load_xfer_n;
    logic [3:0] assertlow_main_n, asserthigh_main_n;
    logic [3:0] loadlow_main_n, loadhigh_main_n;

    always #5 clk = ~clk;

    xfer_word_mover #(.NUM_REGS(4), .WIDTH_SEL(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_src           (req_src),
        .req_dst           (req_dst),
        .req_mode          (req_mode),
        .busy              (busy),
        .done              (done),
        .assert_xfer_n     (assert_xfer_n),
        .load_xfer_n       (load_xfer_n),
        .assertlow_main_n  (assertlow_main_n),
        .asserthigh_main_n (asserthigh_main_n),
        .loadlow_main_n    (loadlow_main_n),
        .loadhigh_main_n   (loadhigh_main_n)
    );

    // Record: {ready, busy, done, ax, lx, al, ah, ll, lh}
    typedef logic [26:0] rec_t;
    localparam logic [3:0] OFF = 4'hF;

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input rec_t got, input rec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (ready,busy,done,ax,lx,al,ah,ll,lh)", tag, got, exp);
        end
    endtask

    function automatic rec_t mk(input logic b, input logic d,
                                input logic [3:0] ax, input logic [3:0] lx,
                                input logic [3:0] al, input logic [3:0] ah,
                                input logic [3:0] ll, input logic [3:0] lh);
        return {~b, b, d, ax, lx, al, ah, ll, lh};
    endfunction

    function automatic logic [3:0] oh_n(input logic [1:0] idx);
        logic [3:0] v;
        v = OFF;
        v[idx] = 1'b0;
        return v;
    endfunction

    function automatic rec_t actual();
        return {req_ready, busy, done, assert_xfer_n, load_xfer_n,
                assertlow_main_n, asserthigh_main_n, loadlow_main_n, loadhigh_main_n};
    endfunction

    task automatic cyc(input string tag);
        rec_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = mk(1'b0, 1'b0, OFF, OFF, OFF, OFF, OFF, OFF);
        chk(tag, actual(), e);
    endtask

    task automatic push_move(input logic [1:0] s, input logic [1:0] d, input logic m);
        logic [3:0] sx, dx;
        sx = (s != d) ? oh_n(s) : OFF;
        dx = (s != d) ? oh_n(d) : OFF;
`ifdef XFER_MOVER_BYTE_EN
        if (m) begin
            exp_q.push_back(mk(1'b1, 1'b0, OFF, OFF, sx, OFF, dx, OFF));
            exp_q.push_back(mk(1'b1, 1'b0, OFF, OFF, OFF, sx, OFF, dx));
        end else begin
            exp_q.push_back(mk(1'b1, 1'b0, sx, dx, OFF, OFF, OFF, OFF));
        end
`else
        if (m) sx = sx;
        exp_q.push_back(mk(1'b1, 1'b0, sx, dx, OFF, OFF, OFF, OFF));
`endif
        exp_q.push_back(mk(1'b0, 1'b1, OFF, OFF, OFF, OFF, OFF, OFF));
    endtask

    // Returns inside the done cycle, so a following move is back-to-back.
    task automatic move(input string tag, input logic [1:0] s, input logic [1:0] d,
                        input logic m, input logic hold);
        int n;
        req_src   = s;
        req_dst   = d;
        req_mode  = m;
        req_valid = 1'b1;
        push_move(s, d, m);
        n = exp_q.size();
        cyc(tag);
        if (!hold) req_valid = 1'b0;
        repeat (n - 1) cyc(tag);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        req_mode  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", actual(), mk(1'b0, 1'b0, OFF, OFF, OFF, OFF, OFF, OFF));
        reset = 1'b0;
        repeat (3) cyc("idle");

        move("xfer_1_2", 2'd1, 2'd2, 1'b0, 1'b0);
        cyc("idle_after_xfer");

        move("main_3_0", 2'd3, 2'd0, 1'b1, 1'b0);
        cyc("idle_after_main");

        // Request held high across both moves; busy cycles must ignore it.
        move("b2b_first", 2'd0, 2'd3, 1'b0, 1'b1);
        move("b2b_second", 2'd2, 2'd1, 1'b0, 1'b0);
        repeat (2) cyc("idle_after_b2b");

        move("same_2_2", 2'd2, 2'd2, 1'b1, 1'b0);
        cyc("idle_after_same");

        // Reset during the first strobe cycle of a main move.
        req_src   = 2'd1;
        req_dst   = 2'd3;
        req_mode  = 1'b1;
        req_valid = 1'b1;
        push_move(2'd1, 2'd3, 1'b1);
        cyc("rst_mid_first");
        req_valid = 1'b0;
        reset     = 1'b1;
        exp_q.delete();
        cyc("rst_mid_forced_idle");
        reset = 1'b0;
        repeat (3) cyc("rst_mid_no_done");

        for (int i = 0; i < 24; i++) begin
            logic [1:0] s, d;
            logic       m;
            int         gap;
            s   = 2'($urandom_range(0, 3));
            d   = 2'($urandom_range(0, 3));
            m   = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 2);
            move("rand_move", s, d, m, 1'b0);
            repeat (gap) cyc("rand_gap");
        end
        repeat (2) cyc("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
